// File: rtl/gpu_pkg.sv
// Shared GPU constants: read-buffer opcode, FMA/line/word geometry and the
// assembly round encoding used by the write buffer and the memory block.
package gpu_pkg;

  localparam logic [3:0] OP_READ_BUFFER  = 4'b1010;
  localparam int         GPU_FMA_COUNT   = 2;
  localparam int         GPU_WORD_WIDTH  = 16;
  localparam int         GPU_LINE_WIDTH  = GPU_FMA_COUNT * 3 * GPU_WORD_WIDTH;
  localparam int         GPU_INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    ROUND_0 = 2'd0,
    ROUND_1 = 2'd1,
    ROUND_2 = 2'd2
  } round_e;

  function automatic logic is_read_buffer(input logic [3:0] opcode);
    return opcode == OP_READ_BUFFER;
  endfunction

endpackage

// File: rtl/fma_write_buffer_line_fifo2.sv
// Two-entry line FIFO for the FMA write buffer. Storage is not reset; the
// head is masked to zero while empty so stale lines never leak out.
module line_fifo2 #(
  parameter int WIDTH = 96
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count == 2'd0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fma_write_buffer.sv
// Packs three beats of FMA results into a cache line and queues it for memory.
// Optional sticky overflow/underflow flags are built when WRITE_BUFFER_ERR_EN is defined.
module fma_write_buffer
  import gpu_pkg::*;
#(
  parameter int FMA_COUNT         = GPU_FMA_COUNT,
  parameter int WORD_WIDTH        = GPU_WORD_WIDTH,
  parameter int LINE_WIDTH        = GPU_LINE_WIDTH,
  parameter int INSTRUCTION_WIDTH = GPU_INSTR_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_result_in,
  input  logic                           fma_valid_in,
  output logic                           fma_ready_out,
  input  logic [0:INSTRUCTION_WIDTH-1]   instr_in,
  input  logic                           instr_valid_in,
  output logic [LINE_WIDTH-1:0]          buffer_read_out,
  output logic                           buffer_valid_out,
  output logic [1:0]                     err_out
);

  round_e                round_q;
  logic [LINE_WIDTH-1:0] asm_q;
  logic [LINE_WIDTH-1:0] line_next;
  logic [1:0]            count;
  logic                  read_op;
  logic                  accept;
  logic                  commit;
  logic                  pop;
  logic                  unused_instr;

  assign unused_instr  = ^instr_in[4:INSTRUCTION_WIDTH-1];
  assign read_op       = instr_valid_in && is_read_buffer(instr_in[0:3]);
  assign fma_ready_out = !((count == 2'd2) && (round_q == ROUND_2));
  assign accept        = fma_valid_in && fma_ready_out;
  assign commit        = accept && (round_q == ROUND_2);
  assign pop           = read_op && (count != 2'd0);

  // Word w = round*FMA_COUNT + i lands MSB-first in the line.
  always_comb begin
    line_next = asm_q;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < FMA_COUNT; i++) begin
        if (round_q == 2'(r))
          line_next[LINE_WIDTH-(r*FMA_COUNT+i+1)*WORD_WIDTH +: WORD_WIDTH] =
            fma_result_in[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      round_q <= ROUND_0;
      asm_q   <= '0;
    end else if (accept) begin
      if (commit) begin
        round_q <= ROUND_0;
        asm_q   <= '0;
      end else begin
        round_q <= (round_q == ROUND_0) ? ROUND_1 : ROUND_2;
        asm_q   <= line_next;
      end
    end
  end

  line_fifo2 #(.WIDTH(LINE_WIDTH)) u_line_fifo2 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (commit),
    .push_data (line_next),
    .pop       (pop),
    .head      (buffer_read_out),
    .count     (count)
  );

  assign buffer_valid_out = (count != 2'd0);

`ifdef WRITE_BUFFER_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_q <= 2'b00;
    end else begin
      if (fma_valid_in && !fma_ready_out) err_q[0] <= 1'b1;
      if (read_op && (count == 2'd0))     err_q[1] <= 1'b1;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 2'b00;
`endif

endmodule

// File: tb/tb_fma_write_buffer.sv
// Scoreboard bench for fma_write_buffer: expected lines are queued as beats
// are driven and compared against the head when the buffer presents it.
module tb_fma_write_buffer;
  import gpu_pkg::*;

`ifdef WRITE_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] fma_result_in;
  logic        fma_valid_in;
  logic        fma_ready_out;
  logic [0:31] instr_in;
  logic        instr_valid_in;
  logic [95:0] buffer_read_out;
  logic        buffer_valid_out;
  logic [1:0]  err_out;

  int total = 0;
  int bad   = 0;

  logic [95:0] exp_q[$];
  logic [15:0] m_words[$];
  int          m_round;
  logic [1:0]  m_err;

  always #5 clk_in = ~clk_in;

  fma_write_buffer dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .fma_result_in    (fma_result_in),
    .fma_valid_in     (fma_valid_in),
    .fma_ready_out    (fma_ready_out),
    .instr_in         (instr_in),
    .instr_valid_in   (instr_valid_in),
    .buffer_read_out  (buffer_read_out),
    .buffer_valid_out (buffer_valid_out),
    .err_out          (err_out)
  );

  function automatic logic m_ready();
    return !(exp_q.size() == 2 && m_round == 2);
  endfunction

  function automatic logic [95:0] m_head();
    return (exp_q.size() != 0) ? exp_q[0] : 96'h0;
  endfunction

  // One clock: drive inputs, update the model, advance past the edge.
  task automatic cyc(input logic fv, input logic [15:0] a0, input logic [15:0] a1,
                     input logic iv, input logic [3:0] op);
    logic        acc;
    logic        rd;
    logic [95:0] ln;
    fma_valid_in   = fv;
    fma_result_in  = {a1, a0};
    instr_valid_in = iv;
    instr_in       = $urandom;
    instr_in[0:3]  = op;
    acc = fv && m_ready();
    rd  = iv && (op == 4'b1010);
    if (fv && !m_ready()) m_err[0] = 1'b1;
    if (rd && exp_q.size() == 0) m_err[1] = 1'b1;
    if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      m_words.push_back(a0);
      m_words.push_back(a1);
      m_round++;
      if (m_round == 3) begin
        ln = '0;
        foreach (m_words[k]) ln = {ln[79:0], m_words[k]};
        exp_q.push_back(ln);
        m_words.delete();
        m_round = 0;
      end
    end
    @(posedge clk_in);
    #1;
    fma_valid_in   = 1'b0;
    instr_valid_in = 1'b0;
  endtask

  task automatic do_reset(input logic fv);
    rst_in         = 1'b1;
    fma_valid_in   = fv;
    fma_result_in  = 32'hDEAD_BEEF;
    instr_valid_in = fv;
    instr_in       = '0;
    instr_in[0:3]  = 4'b1010;
    @(posedge clk_in);
    #1;
    rst_in         = 1'b0;
    fma_valid_in   = 1'b0;
    instr_valid_in = 1'b0;
    exp_q.delete();
    m_words.delete();
    m_round = 0;
    m_err   = 2'b00;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (fma_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", fma_ready_out); end
    total++; if (buffer_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", buffer_valid_out); end
    total++; if (buffer_read_out !== 96'h0) begin bad++; $display("FAIL reset_read got=%h want=0", buffer_read_out); end
    total++; if (err_out !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", err_out); end
  endtask

  task automatic test_single_line();
    do_reset(1'b0);
    cyc(1'b1, 16'h1111, 16'h2222, 1'b0, 4'h0);
    cyc(1'b1, 16'h3333, 16'h4444, 1'b0, 4'h0);
    total++; if (buffer_valid_out !== 1'b0) begin bad++; $display("FAIL partial_valid got=%b want=0", buffer_valid_out); end
    cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 4'h0);
    total++; if (buffer_valid_out !== 1'b1) begin bad++; $display("FAIL line_valid got=%b want=1", buffer_valid_out); end
    total++; if (buffer_read_out !== 96'h1111_2222_3333_4444_5555_6666) begin bad++; $display("FAIL line_data got=%h want=111122223333444455556666", buffer_read_out); end
    total++; if (buffer_read_out !== m_head()) begin bad++; $display("FAIL line_sb got=%h want=%h", buffer_read_out, m_head()); end
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1010);
    total++; if (buffer_valid_out !== 1'b0 || buffer_read_out !== 96'h0) begin bad++; $display("FAIL pop_empty got=%b/%h want=0/0", buffer_valid_out, buffer_read_out); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int b = 0; b < 8; b++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 4'h0);
    total++; if (fma_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", fma_ready_out); end
    total++; if (buffer_read_out !== m_head()) begin bad++; $display("FAIL full_head got=%h want=%h", buffer_read_out, m_head()); end
    cyc(1'b1, 16'hBAD0, 16'hBAD1, 1'b0, 4'h0);
    total++; if (err_out !== (ERR_EN ? m_err : 2'b00)) begin bad++; $display("FAIL overflow_err got=%b want=%b", err_out, ERR_EN ? m_err : 2'b00); end
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1010);
    total++; if (fma_ready_out !== 1'b1) begin bad++; $display("FAIL after_pop_ready got=%b want=1", fma_ready_out); end
    total++; if (buffer_read_out !== m_head() || buffer_valid_out !== 1'b1) begin bad++; $display("FAIL second_line got=%h want=%h", buffer_read_out, m_head()); end
    cyc(1'b1, 16'hC0C0, 16'hC1C1, 1'b0, 4'h0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1010);
    total++; if (buffer_read_out !== m_head() || m_head()[15:0] !== 16'hC1C1) begin bad++; $display("FAIL third_line got=%h want=%h", buffer_read_out, m_head()); end
  endtask

  task automatic test_commit_pop();
    do_reset(1'b0);
    for (int b = 0; b < 5; b++)
      cyc(1'b1, 16'(16'hA000 + b), 16'(16'hB000 + b), 1'b0, 4'h0);
    cyc(1'b1, 16'hA005, 16'hB005, 1'b1, 4'b1010);
    total++; if (buffer_valid_out !== 1'b1 || exp_q.size() != 1) begin bad++; $display("FAIL cp_count got=%b want=1", buffer_valid_out); end
    total++; if (buffer_read_out !== 96'hA003_B003_A004_B004_A005_B005) begin bad++; $display("FAIL cp_line got=%h want=a003b003a004b004a005b005", buffer_read_out); end
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1010);
    total++; if (buffer_valid_out !== 1'b0) begin bad++; $display("FAIL cp_drain got=%b want=0", buffer_valid_out); end
  endtask

  task automatic test_other_opcodes();
    logic [95:0] held;
    do_reset(1'b0);
    for (int b = 0; b < 3; b++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 4'h0);
    held = m_head();
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b0111);
    total++; if (buffer_read_out !== held || buffer_valid_out !== 1'b1) begin bad++; $display("FAIL op0111 got=%h want=%h", buffer_read_out, held); end
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1100);
    total++; if (buffer_read_out !== held || buffer_valid_out !== 1'b1) begin bad++; $display("FAIL op1100 got=%h want=%h", buffer_read_out, held); end
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 4'b1010);
    total++; if (buffer_read_out !== held || buffer_valid_out !== 1'b1) begin bad++; $display("FAIL novalid got=%h want=%h", buffer_read_out, held); end
  endtask

  task automatic test_reset_mid_line();
    do_reset(1'b0);
    cyc(1'b1, 16'hEEEE, 16'hEEEE, 1'b0, 4'h0);
    cyc(1'b1, 16'hEEEE, 16'hEEEE, 1'b0, 4'h0);
    do_reset(1'b1);
    total++; if (buffer_valid_out !== 1'b0 || fma_ready_out !== 1'b1) begin bad++; $display("FAIL midrst_state got=%b/%b want=0/1", buffer_valid_out, fma_ready_out); end
    cyc(1'b1, 16'h0101, 16'h0202, 1'b0, 4'h0);
    cyc(1'b1, 16'h0303, 16'h0404, 1'b0, 4'h0);
    cyc(1'b1, 16'h0505, 16'h0606, 1'b0, 4'h0);
    total++; if (buffer_read_out !== 96'h0101_0202_0303_0404_0505_0606) begin bad++; $display("FAIL midrst_line got=%h want=010102020303040405050606", buffer_read_out); end
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1010);
    total++; if (buffer_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_one got=%b want=0", buffer_valid_out); end
  endtask

  task automatic test_err();
    logic [1:0] want;
    want = ERR_EN ? 2'b10 : 2'b00;
    do_reset(1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 4'b1010);
    total++; if (err_out !== want) begin bad++; $display("FAIL underflow_err got=%b want=%b", err_out, want); end
    total++; if (buffer_valid_out !== 1'b0) begin bad++; $display("FAIL underflow_valid got=%b want=0", buffer_valid_out); end
    for (int b = 0; b < 3; b++)
      cyc(1'b1, 16'h7777, 16'h8888, 1'b0, 4'h0);
    total++; if (err_out !== want) begin bad++; $display("FAIL underflow_hold got=%b want=%b", err_out, want); end
    do_reset(1'b0);
    total++; if (err_out !== 2'b00) begin bad++; $display("FAIL err_clear got=%b want=00", err_out); end
  endtask

  initial begin
    rst_in         = 1'b1;
    fma_valid_in   = 1'b0;
    fma_result_in  = '0;
    instr_valid_in = 1'b0;
    instr_in       = '0;
    m_round        = 0;
    m_err          = 2'b00;
    test_reset();
    test_single_line();
    test_backpressure();
    test_commit_pop();
    test_other_opcodes();
    test_reset_mid_line();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fma_write_buffer.md
FMA_WRITE_BUFFER -- requirements
Module: fma_write_buffer

Interface
REQ-001 SHALL have parameter FMA_COUNT, default 2, meaning the number of FMAs delivering one result word each per beat.
REQ-002 SHALL have parameter WORD_WIDTH, default 16, meaning the bits per result word.
REQ-003 SHALL have parameter LINE_WIDTH, default 96, meaning FMA_COUNT*3*WORD_WIDTH, the bits per data-cache line.
REQ-004 SHALL have parameter INSTRUCTION_WIDTH, default 32, meaning the bits per instruction.
REQ-005 SHALL have port clk_in, input, 1 bit, the single clock.
REQ-006 SHALL have port rst_in, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port fma_result_in, input, FMA_COUNT*WORD_WIDTH bits, with FMA i's word at [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 SHALL have port fma_valid_in, input, 1 bit, meaning all FMA results are valid this cycle.
REQ-009 SHALL have port fma_ready_out, output, 1 bit, meaning the buffer accepts a beat this cycle.
REQ-010 SHALL have port instr_in, input, [0:INSTRUCTION_WIDTH-1], the snooped instruction bus (opcode in bits [0:3]).
REQ-011 SHALL have port instr_valid_in, input, 1 bit, the snooped instruction valid.
REQ-012 SHALL have port buffer_read_out, output, LINE_WIDTH bits, the head line presented to memory.
REQ-013 SHALL have port buffer_valid_out, output, 1 bit, meaning the head line is valid; held high until consumed.
REQ-014 SHALL have port err_out, output, 2 bits: [0] overflow, [1] underflow (see REQ-027).

Function
REQ-015 SHALL accept a beat only when fma_valid_in && fma_ready_out are both high in the same cycle.
REQ-016 SHALL track a round counter 0..2, packing FMA i's word of round r into line word index w=r*FMA_COUNT+i, at bits [LINE_WIDTH-(w+1)*WORD_WIDTH +: WORD_WIDTH].
REQ-017 SHALL, on the beat that completes round 2, commit the assembled line (including that beat's words) into a 2-entry line FIFO and wrap the round counter to 0.
REQ-018 SHALL compute fma_ready_out = !(count==2 && round==2), combinationally from registered state only, independent of any pop in the same cycle.
REQ-019 SHALL drive buffer_read_out = FIFO head line and buffer_valid_out = (count!=0), both purely from registers.
REQ-020 SHALL pop the head when instr_valid_in && instr_in[0:3]==4'b1010 && count!=0; memory samples the line in that same cycle.
REQ-021 SHALL, on a simultaneous commit and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL ignore all other opcodes; a 4'b1010 with count==0 pops nothing.
REQ-023 SHALL toggle both pointers modulo 2 and keep count in the range 0..2.

Reset
REQ-024 SHALL, while rst_in is high, clear round, pointers, count, assembly register and err_out, giving fma_ready_out=1, buffer_valid_out=0 and buffer_read_out=0 on the following cycle.
REQ-025 SHALL, on reset mid-line or mid-handshake, discard the partial line and all queued lines with no commit and no pop.
REQ-026 SHALL NOT reset FIFO storage contents; buffer_read_out SHALL be masked to 0 while count==0.

Configuration
REQ-027 SHALL, when WRITE_BUFFER_ERR_EN is defined, set err_out[0] sticky when fma_valid_in is high while fma_ready_out is low, and set err_out[1] sticky when a 4'b1010 is snooped with count==0; both bits clear only on reset.
REQ-028 SHALL, when WRITE_BUFFER_ERR_EN is undefined, tie err_out to 2'b00 and synthesise no error logic.

Structure
REQ-029 SHALL import the opcode constant OP_READ_BUFFER=4'b1010 and the line/word width constants from the shared package gpu_pkg, which the memory block also uses.
REQ-030 SHALL place the 2-entry line FIFO in the sub-module line_fifo2 (push, pop, head, count); the packing and round logic SHALL stay in the top level.

Verification
REQ-031 Three beats with results {0x1111,0x2222}, {0x3333,0x4444}, {0x5555,0x6666} SHALL produce buffer_valid_out=1 on the cycle after the third beat, with buffer_read_out=0x111122223333444455556666.
REQ-032 With two lines queued and round==2, fma_ready_out SHALL be 0; a snooped 4'b1010 SHALL restore fma_ready_out=1 the next cycle and present the second line.
REQ-033 A third-beat commit in the same cycle as a 4'b1010 pop with count==1 SHALL keep count==1 and present the new line next.
REQ-034 A snooped 4'b0111 or 4'b1100 with count==1 SHALL leave the line and buffer_valid_out unchanged.
REQ-035 Asserting rst_in after two beats SHALL be followed by three fresh beats that yield exactly one line, with no stale words from before reset.
REQ-036 With WRITE_BUFFER_ERR_EN defined, a 4'b1010 at count==0 SHALL set err_out to 2'b10 and hold it until reset.
